// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU input path.
// Used by the skew feeder and its tile registers.
package tpu_pkg;

    localparam int DATA_W = 8;
    localparam int SKEW_STEPS = 3;
    localparam logic [1:0] LAST_STEP = 2'(SKEW_STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/tile_reg.sv
// Four-element tile register, layout {m00, m01, m10, m11}.
// Synchronous load enable, asynchronous active-high reset.
module tile_reg #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DATA_W-1:0]   d,
    output logic [4*DATA_W-1:0]   q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/input_skew_feeder.sv
// Captures 2x2 tiles from the unified buffer and streams them
// into the two systolic array rows with one-cycle diagonal skew.
module input_skew_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W = tpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_input,
    input  logic [DATA_W-1:0] ub_00,
    input  logic [DATA_W-1:0] ub_01,
    input  logic [DATA_W-1:0] ub_10,
    input  logic [DATA_W-1:0] ub_11,
    input  logic              hold,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              valid_in1,
    output logic              valid_in2,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int TW = 4 * DATA_W;

    feeder_state_t state, state_n;
    logic [1:0]    step, step_n;
    logic          load_d;
    logic          pend_v, pend_v_n;
    logic          done_n, ovf_n;
    logic          act_ld, pend_ld;
    logic [TW-1:0] cap_tile, act_d, act_q, pend_q;
    logic          cap, complete;

    assign cap      = load_d;
    assign cap_tile = {ub_00, ub_01, ub_10, ub_11};
    assign complete = (state == FEED) && (step == LAST_STEP) && !hold;

    tile_reg #(.DATA_W(DATA_W)) u_active (
        .clk   (clk),
        .reset (reset),
        .load  (act_ld),
        .d     (act_d),
        .q     (act_q)
    );

    tile_reg #(.DATA_W(DATA_W)) u_pending (
        .clk   (clk),
        .reset (reset),
        .load  (pend_ld),
        .d     (cap_tile),
        .q     (pend_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            load_d   <= 1'b0;
            pend_v   <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            load_d   <= load_input;
            pend_v   <= pend_v_n;
            done     <= done_n;
            overflow <= ovf_n;
        end
    end

    always_comb begin
        state_n  = state;
        step_n   = step;
        pend_v_n = pend_v;
        act_ld   = 1'b0;
        act_d    = cap_tile;
        pend_ld  = 1'b0;
        done_n   = 1'b0;
        ovf_n    = overflow & ~clr_overflow;
        case (state)
            IDLE: begin
                if (cap) begin
                    act_ld  = 1'b1;
                    step_n  = '0;
                    state_n = FEED;
                end
            end
            FEED: begin
                if (!hold) begin
                    step_n = step + 2'd1;
                end
                if (complete) begin
                    done_n = 1'b1;
                    step_n = '0;
                    if (pend_v) begin
                        // Promote pending; a coincident capture refills it.
                        act_ld   = 1'b1;
                        act_d    = pend_q;
                        pend_ld  = cap;
                        pend_v_n = cap;
                    end else if (cap) begin
                        act_ld = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (cap) begin
                    if (!pend_v) begin
                        pend_ld  = 1'b1;
                        pend_v_n = 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        a_in1     = '0;
        a_in2     = '0;
        valid_in1 = 1'b0;
        valid_in2 = 1'b0;
        if (state == FEED && !hold) begin
            case (step)
                2'd0: begin
                    a_in1     = act_q[TW-1 -: DATA_W];
                    valid_in1 = 1'b1;
                end
                2'd1: begin
                    a_in1     = act_q[TW-DATA_W-1 -: DATA_W];
                    a_in2     = act_q[2*DATA_W-1 -: DATA_W];
                    valid_in1 = 1'b1;
                    valid_in2 = 1'b1;
                end
                2'd2: begin
                    a_in2     = act_q[DATA_W-1:0];
                    valid_in2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == FEED) | pend_v;

endmodule
